lap_display_ctrl: RTL and testbench

Lap/split controller between the time core and the display multiplexer of the stopwatch. It captures the live MM:SS digits into a small ring of lap registers and decides which value drives the four digits: the live time, a frozen split, or a recalled lap. It sequences the split-hold and recall browsing with the 1 Hz tick. It also tells the display path when a non-live value is shown.

---
 rtl/lap_display_ctrl_if.sv | 29 ++
 rtl/lap_display_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lap_display_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lap_display_ctrl_if.sv
// Request/display bundle between the stopwatch time core, the lap controller
// and the display multiplexer.
interface lap_display_ctrl_if #(
    parameter int LAP_DEPTH = 4
);
    localparam int IDX_W = $clog2(LAP_DEPTH);

    logic             tick_1hz;
    logic [15:0]      live_digits;
    logic             lap_req;
    logic             recall_req;
    logic             clear_req;
    logic [15:0]      disp_digits;
    logic             showing_lap;
    logic [IDX_W-1:0] lap_index;
    logic [IDX_W:0]   lap_count;
    logic             recall_empty;
    logic             disp_blink;

    modport master (
        output tick_1hz, live_digits, lap_req, recall_req, clear_req,
        input  disp_digits, showing_lap, lap_index, lap_count, recall_empty, disp_blink
    );

    modport slave (
        input  tick_1hz, live_digits, lap_req, recall_req, clear_req,
        output disp_digits, showing_lap, lap_index, lap_count, recall_empty, disp_blink
    );
endinterface

// File: rtl/lap_display_ctrl.sv
// Stopwatch lap/split controller: lap ring, split hold, recall browsing.
// Define LAP_DISPLAY_BLINK_EN to drive disp_blink from showing_lap; otherwise it is tied low.
module lap_display_ctrl #(
    parameter int LAP_DEPTH  = 4,
    parameter int HOLD_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    lap_display_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(LAP_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

    typedef enum logic [1:0] {
        ST_LIVE   = 2'd0,
        ST_SPLIT  = 2'd1,
        ST_RECALL = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] wp, wp_nxt;
    logic [IDX_W-1:0] lap_index, lap_index_nxt;
    logic [CNT_W-1:0] lap_count, lap_count_nxt;
    logic [3:0]       hold_cnt, hold_cnt_nxt;
    logic [IDX_W-1:0] rd_ptr;
    logic [15:0]      slots [LAP_DEPTH];
    logic [15:0]      disp_digits, disp_nxt;
    logic             showing_lap;
    logic             recall_empty, recall_empty_nxt;
    logic             capture;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_FULL)
            return CNT_FULL;
        return c + CNT_W'(1);
    endfunction

    // Event arbitration: clear > lap > recall > tick; losers are dropped.
    always_comb begin
        state_nxt        = state;
        wp_nxt           = wp;
        lap_count_nxt    = lap_count;
        lap_index_nxt    = lap_index;
        hold_cnt_nxt     = hold_cnt;
        capture          = 1'b0;
        recall_empty_nxt = 1'b0;

        if (bus.clear_req) begin
            state_nxt     = ST_LIVE;
            wp_nxt        = '0;
            lap_count_nxt = '0;
            lap_index_nxt = '0;
            hold_cnt_nxt  = '0;
        end else if (bus.lap_req) begin
            capture       = 1'b1;
            wp_nxt        = wp + IDX_W'(1);
            lap_count_nxt = sat_inc(lap_count);
            state_nxt     = ST_SPLIT;
            lap_index_nxt = '0;
            hold_cnt_nxt  = HOLD_LOAD;
        end else if (bus.recall_req) begin
            case (state)
                ST_LIVE: begin
                    if (lap_count == '0) begin
                        recall_empty_nxt = 1'b1;
                    end else begin
                        state_nxt     = ST_RECALL;
                        lap_index_nxt = '0;
                        hold_cnt_nxt  = HOLD_LOAD;
                    end
                end
                ST_SPLIT: begin
                    state_nxt     = ST_RECALL;
                    lap_index_nxt = '0;
                    hold_cnt_nxt  = HOLD_LOAD;
                end
                ST_RECALL: begin
                    if ((CNT_W'(lap_index) + CNT_W'(1)) < lap_count) begin
                        lap_index_nxt = lap_index + IDX_W'(1);
                        hold_cnt_nxt  = HOLD_LOAD;
                    end else begin
                        state_nxt     = ST_LIVE;
                        lap_index_nxt = '0;
                        hold_cnt_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt     = ST_LIVE;
                    lap_index_nxt = '0;
                    hold_cnt_nxt  = '0;
                end
            endcase
        end else if (bus.tick_1hz && (state != ST_LIVE)) begin
            if (hold_cnt == 4'd1) begin
                state_nxt     = ST_LIVE;
                lap_index_nxt = '0;
                hold_cnt_nxt  = '0;
            end else begin
                hold_cnt_nxt = hold_cnt - 4'd1;
            end
        end
    end

    // Source selection for the registered display value, based on where we land.
    always_comb begin
        rd_ptr   = wp_nxt - IDX_W'(1) - lap_index_nxt;
        disp_nxt = bus.live_digits;
        case (state_nxt)
            ST_LIVE:   disp_nxt = bus.live_digits;
            ST_SPLIT:  disp_nxt = capture ? bus.live_digits : disp_digits;
            ST_RECALL: disp_nxt = slots[rd_ptr];
            default:   disp_nxt = bus.live_digits;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_LIVE;
            wp           <= '0;
            lap_count    <= '0;
            lap_index    <= '0;
            hold_cnt     <= '0;
            disp_digits  <= 16'h0000;
            showing_lap  <= 1'b0;
            recall_empty <= 1'b0;
        end else begin
            state        <= state_nxt;
            wp           <= wp_nxt;
            lap_count    <= lap_count_nxt;
            lap_index    <= lap_index_nxt;
            hold_cnt     <= hold_cnt_nxt;
            disp_digits  <= disp_nxt;
            showing_lap  <= (state_nxt != ST_LIVE);
            recall_empty <= recall_empty_nxt;
        end
    end

    // Lap storage carries no reset; stale slots are unreachable once lap_count is cleared.
    always_ff @(posedge clk) begin
        if (rst_n && capture)
            slots[wp] <= bus.live_digits;
    end

    assign bus.disp_digits  = disp_digits;
    assign bus.showing_lap  = showing_lap;
    assign bus.lap_index    = lap_index;
    assign bus.lap_count    = lap_count;
    assign bus.recall_empty = recall_empty;

`ifdef LAP_DISPLAY_BLINK_EN
    logic disp_blink;

    always_ff @(posedge clk) begin
        if (!rst_n)
            disp_blink <= 1'b0;
        else
            disp_blink <= (state_nxt != ST_LIVE);
    end

    assign bus.disp_blink = disp_blink;
`else
    assign bus.disp_blink = 1'b0;
`endif

endmodule

// File: tb/tb_lap_display_ctrl.sv
// Randomized self-checking bench for lap_display_ctrl against a queue-based lap model.
module tb_lap_display_ctrl;
    localparam int LAP_DEPTH  = 4;
    localparam int HOLD_TICKS = 3;
    localparam int M_LIVE   = 0;
    localparam int M_SPLIT  = 1;
    localparam int M_RECALL = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    lap_display_ctrl_if #(.LAP_DEPTH(LAP_DEPTH)) bus ();

    lap_display_ctrl #(
        .LAP_DEPTH (LAP_DEPTH),
        .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: laps kept oldest-first, newest at the back.
    logic [15:0] laps [$];
    int          m_mode = M_LIVE;
    int          m_idx  = 0;
    int          m_hold = 0;
    logic [15:0] m_disp = 16'h0000;
    bit          m_empty = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_step(input bit rstn, input bit tick, input bit lap, input bit rec,
                              input bit clr, input logic [15:0] live);
        m_empty = 1'b0;
        if (!rstn) begin
            laps.delete();
            m_mode = M_LIVE;
            m_idx  = 0;
            m_hold = 0;
            m_disp = 16'h0000;
            return;
        end
        if (clr) begin
            laps.delete();
            m_mode = M_LIVE;
            m_idx  = 0;
            m_hold = 0;
        end else if (lap) begin
            if (laps.size() == LAP_DEPTH)
                void'(laps.pop_front());
            laps.push_back(live);
            m_mode = M_SPLIT;
            m_idx  = 0;
            m_hold = HOLD_TICKS;
        end else if (rec) begin
            if (m_mode == M_LIVE) begin
                if (laps.size() == 0) begin
                    m_empty = 1'b1;
                end else begin
                    m_mode = M_RECALL;
                    m_idx  = 0;
                    m_hold = HOLD_TICKS;
                end
            end else if (m_mode == M_SPLIT) begin
                m_mode = M_RECALL;
                m_idx  = 0;
                m_hold = HOLD_TICKS;
            end else if (m_idx + 1 < laps.size()) begin
                m_idx++;
                m_hold = HOLD_TICKS;
            end else begin
                m_mode = M_LIVE;
                m_idx  = 0;
            end
        end else if (tick && m_mode != M_LIVE) begin
            if (m_hold == 1) begin
                m_mode = M_LIVE;
                m_idx  = 0;
            end
            m_hold--;
        end
        case (m_mode)
            M_SPLIT:  m_disp = laps[laps.size() - 1];
            M_RECALL: m_disp = laps[laps.size() - 1 - m_idx];
            default:  m_disp = live;
        endcase
    endtask

    task automatic cyc(input bit rstn, input bit tick, input bit lap, input bit rec,
                       input bit clr, input logic [15:0] live);
        bit exp_show;
        @(negedge clk);
        rst_n           = rstn;
        bus.tick_1hz    = tick;
        bus.lap_req     = lap;
        bus.recall_req  = rec;
        bus.clear_req   = clr;
        bus.live_digits = live;
        model_step(rstn, tick, lap, rec, clr, live);
        @(posedge clk);
        #1;
        cycle++;
        exp_show = (m_mode != M_LIVE);
        check("disp_digits", bus.disp_digits, m_disp);
        check("showing_lap", bus.showing_lap, exp_show);
        check("lap_index", bus.lap_index, m_idx);
        check("lap_count", bus.lap_count, laps.size());
        check("recall_empty", bus.recall_empty, m_empty);
`ifdef LAP_DISPLAY_BLINK_EN
        check("disp_blink", bus.disp_blink, exp_show);
`else
        check("disp_blink", bus.disp_blink, 1'b0);
`endif
    endtask

    initial begin
        logic [15:0] live;
        rst_n           = 1'b0;
        bus.tick_1hz    = 1'b0;
        bus.lap_req     = 1'b0;
        bus.recall_req  = 1'b0;
        bus.clear_req   = 1'b0;
        bus.live_digits = 16'h0000;

        cyc(0, 0, 0, 0, 0, 16'h0000);
        cyc(0, 0, 0, 0, 0, 16'h0999);
        cyc(1, 0, 0, 0, 0, 16'h0123);

        // Split hold: live keeps moving, three ticks release it.
        cyc(1, 0, 1, 0, 0, 16'h0145);
        live = 16'h0146;
        for (int i = 0; i < 12; i++) begin
            cyc(1, (i % 3) == 2, 0, 0, 0, live);
            live++;
        end

        // Ring overwrite and recall browsing.
        cyc(1, 0, 0, 0, 1, 16'h0200);
        for (int i = 1; i <= 5; i++)
            cyc(1, 0, 1, 0, 0, 16'(i));
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 1, 0, 16'h0300);
            cyc(1, 0, 0, 0, 0, 16'h0301);
        end

        // Empty recall, then recall losing to a simultaneous lap.
        cyc(1, 0, 0, 0, 1, 16'h0400);
        cyc(1, 0, 0, 1, 0, 16'h0401);
        cyc(1, 0, 0, 0, 0, 16'h0402);
        cyc(1, 0, 1, 1, 0, 16'h0403);
        cyc(1, 0, 0, 0, 0, 16'h0404);

        // Tick in the entry cycle is ignored.
        cyc(1, 1, 1, 0, 0, 16'h0500);
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 0, 0, 0, 16'h0501 + 16'(i));

        // Clear beats lap and recall while recalling.
        cyc(1, 0, 0, 1, 0, 16'h0600);
        cyc(1, 0, 1, 1, 1, 16'h0601);
        cyc(1, 0, 0, 0, 0, 16'h0602);

        // Reset mid-split.
        cyc(1, 0, 1, 0, 0, 16'h0700);
        cyc(0, 0, 0, 0, 0, 16'h0701);
        cyc(1, 0, 0, 0, 0, 16'h0702);

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 499) != 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 99) == 0,
                16'($urandom_range(0, 16'hFFFF)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
